// File: rtl/dabus_packer_pkg.sv
// Shared constants, output beat type and byte-mask helpers for the dabus packer.
package dabus_packer_pkg;

  localparam int unsigned DABUS_BYTES = 8;
  localparam int unsigned DABUS_DW    = 8 * DABUS_BYTES;
  localparam int unsigned DABUS_CNT_W = 5;

  typedef struct packed {
    logic [DABUS_DW-1:0]    data;
    logic [DABUS_BYTES-1:0] keep;
    logic                   last;
  } beat_t;

  // Contiguous LSB mask with n bits set, n = 0..DABUS_BYTES.
  function automatic logic [DABUS_BYTES-1:0] keep_mask(input logic [3:0] n);
    logic [DABUS_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < DABUS_BYTES; i++) begin
      if (i < int'(n)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [3:0] clamp_bytes(input logic [3:0] n);
    return (n > 4'(DABUS_BYTES)) ? 4'(DABUS_BYTES) : n;
  endfunction

endpackage

// File: rtl/dabus_packer_if.sv
// Input (partial word + byte count) and output (packed word + keep) streams of the packer.
interface dabus_packer_if;
  import dabus_packer_pkg::*;

  logic                   s_valid;
  logic                   s_ready;
  logic [DABUS_DW-1:0]    s_data;
  logic [3:0]             s_bytes;
  logic                   s_last;
  logic                   m_valid;
  logic                   m_ready;
  logic [DABUS_DW-1:0]    m_data;
  logic [DABUS_BYTES-1:0] m_keep;
  logic                   m_last;

  modport master (
    output s_valid, s_data, s_bytes, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_keep, m_last
  );

  modport slave (
    input  s_valid, s_data, s_bytes, s_last, m_ready,
    output s_ready, m_valid, m_data, m_keep, m_last
  );

endinterface

// File: rtl/dabus_packer_lane_shift.sv
// Masks an LSB-aligned input word to its byte count and shifts it up by the fill level
// into a double-width window, ready to be ORed into the accumulator.
module dabus_packer_lane_shift
  import dabus_packer_pkg::*;
#(
  parameter int unsigned BYTES = DABUS_BYTES,
  parameter int unsigned CNT_W = DABUS_CNT_W
) (
  input  logic [8*BYTES-1:0]  i_data,
  input  logic [3:0]          i_bytes,
  input  logic [CNT_W-1:0]    i_cnt,
  output logic [16*BYTES-1:0] o_window
);

  logic [BYTES-1:0]   w_keep;
  logic [8*BYTES-1:0] w_masked;

  // Lanes beyond the byte count may carry garbage; zero them so the OR stays clean.
  always_comb begin
    w_keep   = keep_mask(i_bytes);
    w_masked = '0;
    for (int i = 0; i < int'(BYTES); i++) begin
      w_masked[8*i +: 8] = i_data[8*i +: 8] & {8{w_keep[i]}};
    end
  end

  assign o_window = {{(8*BYTES){1'b0}}, w_masked} << {i_cnt, 3'b000};

endmodule

// File: rtl/dabus_packer.sv
// Packs LSB-aligned partial words back-to-back into full words; s_last flushes the residue
// as a final, partially kept beat.
module dabus_packer
  import dabus_packer_pkg::*;
#(
  parameter int unsigned BYTES = DABUS_BYTES,
  parameter int unsigned CNT_W = DABUS_CNT_W
) (
  input logic           i_clk,
  input logic           i_rst_n,
  dabus_packer_if.slave io_bus
);

  localparam int unsigned DW = 8 * BYTES;

  logic [2*DW-1:0]  r_acc, w_acc_nxt, w_window, w_merged_acc;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_merged, w_take;
  logic             r_flush_pend, w_flush_pend_nxt;
  logic             r_m_valid, w_m_valid_nxt;
  beat_t            r_out, w_out_nxt;
  logic [3:0]       w_bytes;
  logic             w_accept, w_free, w_flushing, w_pop;

  assign io_bus.s_ready = i_rst_n & ~r_flush_pend & (r_cnt <= CNT_W'(BYTES));
  assign w_bytes        = clamp_bytes(io_bus.s_bytes);
  assign w_accept       = io_bus.s_valid & io_bus.s_ready;

  dabus_packer_lane_shift #(
    .BYTES (BYTES),
    .CNT_W (CNT_W)
  ) u_lane_shift (
    .i_data   (io_bus.s_data),
    .i_bytes  (w_bytes),
    .i_cnt    (r_cnt),
    .o_window (w_window)
  );

  always_comb begin
    w_merged_acc = r_acc;
    w_merged     = r_cnt;
    if (w_accept) begin
      w_merged_acc = r_acc | w_window;
      w_merged     = r_cnt + CNT_W'(w_bytes);
    end
    w_flushing = r_flush_pend | (w_accept & io_bus.s_last);
    w_free     = ~r_m_valid | io_bus.m_ready;
    // A flush with nothing merged still pops: that is the zero-length last beat.
    w_pop      = w_free & ((w_merged >= CNT_W'(BYTES)) | w_flushing);
    w_take     = (w_merged >= CNT_W'(BYTES)) ? CNT_W'(BYTES) : w_merged;

    w_acc_nxt        = w_merged_acc;
    w_cnt_nxt        = w_merged;
    w_out_nxt        = r_out;
    w_m_valid_nxt    = r_m_valid;
    w_flush_pend_nxt = r_flush_pend | (w_accept & io_bus.s_last);

    if (w_pop) begin
      w_out_nxt.data = w_merged_acc[DW-1:0];
      w_out_nxt.keep = keep_mask(4'(w_take));
      w_out_nxt.last = w_flushing & (w_merged <= CNT_W'(BYTES));
      w_m_valid_nxt  = 1'b1;
      w_acc_nxt      = w_merged_acc >> DW;
      w_cnt_nxt      = w_merged - w_take;
      if (w_out_nxt.last) w_flush_pend_nxt = 1'b0;
    end else if (w_free) begin
      w_m_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_m_valid    <= 1'b0;
      r_out        <= '0;
    end else begin
      r_acc        <= w_acc_nxt;
      r_cnt        <= w_cnt_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      r_m_valid    <= w_m_valid_nxt;
      r_out        <= w_out_nxt;
    end
  end

  assign io_bus.m_valid = r_m_valid;
  assign io_bus.m_data  = r_out.data;
  assign io_bus.m_keep  = r_out.keep;
  assign io_bus.m_last  = r_out.last;

endmodule

// File: tb/tb_dabus_packer.sv
// Bench for dabus_packer: directed scenarios plus random packets against a packet-level model
// that slices each packet's byte stream into 8-byte beats.
module tb_dabus_packer;
  import dabus_packer_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dabus_packer_if bus ();

  dabus_packer u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  bit         rand_ready = 1'b0;
  logic       rnd_bit    = 1'b1;
  logic       tb_ready   = 1'b1;
  logic [7:0] pkt_q[$];
  beat_t      exp_q[$];
  beat_t      obs_q[$];
  int         acc_cyc_q[$];
  int         obs_cyc_q[$];

  assign bus.m_ready = rand_ready ? rnd_bit : tb_ready;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      rnd_bit = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  // Whole packet known: cut it into 8-byte beats, the final one marked last.
  function automatic void model_packet();
    int    n;
    int    k;
    beat_t b;
    n = pkt_q.size();
    if (n == 0) begin
      b.data = '0;
      b.keep = '0;
      b.last = 1'b1;
      exp_q.push_back(b);
    end
    for (int base = 0; base < n; base += 8) begin
      k = (n - base < 8) ? (n - base) : 8;
      b.data = '0;
      for (int j = 0; j < k; j++) b.data[8*j +: 8] = pkt_q[base + j];
      b.keep = 8'((9'd1 << k) - 9'd1);
      b.last = (base + k == n);
      exp_q.push_back(b);
    end
    pkt_q.delete();
  endfunction

  always @(negedge clk) begin : monitor
    beat_t b;
    int    n;
    if (rst_n) begin
      if (bus.m_valid && bus.m_ready) begin
        b.data = bus.m_data;
        b.keep = bus.m_keep;
        b.last = bus.m_last;
        obs_q.push_back(b);
        obs_cyc_q.push_back(cyc);
      end
      if (bus.s_valid && bus.s_ready) begin
        n = (bus.s_bytes > 4'd8) ? 8 : int'(bus.s_bytes);
        for (int j = 0; j < n; j++) pkt_q.push_back(bus.s_data[8*j +: 8]);
        acc_cyc_q.push_back(cyc);
        if (bus.s_last) model_packet();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic [3:0] nb, input logic last);
    int t;
    t = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_bytes = nb;
    bus.s_last  = last;
    while (!bus.s_ready && t < 300) begin
      step();
      t++;
    end
    if (t >= 300) check("send_timeout", 64'(bus.s_ready), 64'd1);
    step();
    bus.s_valid = 1'b0;
    bus.s_data  = {$urandom, $urandom};
    bus.s_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    rand_ready = 1'b0;
    tb_ready   = 1'b1;
    while (obs_q.size() < exp_q.size() && t < 500) begin
      step();
      t++;
    end
    repeat (4) step();
    check("beat_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check("beat_data", obs_q[i].data, exp_q[i].data);
      check("beat_keep", 64'(obs_q[i].keep), 64'(exp_q[i].keep));
      check("beat_last", 64'(obs_q[i].last), 64'(exp_q[i].last));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running, required done");
    $fatal(1);
  end

  initial begin
    logic [63:0] w0;
    int          nw;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_bytes = '0;
    bus.s_last  = 1'b0;

    // Reset state
    step();
    check("ready_in_reset", 64'(bus.s_ready), 64'd0);
    step();
    check("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_m_keep", 64'(bus.m_keep), 64'd0);
    check("rst_m_data", bus.m_data, 64'd0);
    check("rst_m_last", 64'(bus.m_last), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_ready_after", 64'(bus.s_ready), 64'd1);
    step();

    // T1: reset mid-packet discards the 5 accumulated bytes
    send({$urandom, $urandom}, 4'd5, 1'b0);
    rst_n = 1'b0;
    step();
    check("t1_m_valid", 64'(bus.m_valid), 64'd0);
    check("t1_ready_in_reset", 64'(bus.s_ready), 64'd0);
    pkt_q.delete();
    rst_n = 1'b1;
    #1;
    check("t1_ready_release", 64'(bus.s_ready), 64'd1);
    send(64'h0000_0000_00C3_B2A1, 4'd3, 1'b1);
    drain();

    // T2: four full words, one beat one cycle after each accept
    acc_cyc_q.delete();
    obs_cyc_q.delete();
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < 8; j++) w0[8*j +: 8] = 8'(8*w + j);
      send(w0, 4'd8, w == 3);
    end
    for (int i = 0; i < 4 && i < acc_cyc_q.size() && i < obs_cyc_q.size(); i++) begin
      check("t2_latency", 64'(obs_cyc_q[i] - acc_cyc_q[i]), 64'd1);
    end
    drain();

    // T3: odd sizes summing to exactly two words
    send({$urandom, $urandom}, 4'd3, 1'b0);
    send({$urandom, $urandom}, 4'd5, 1'b0);
    send({$urandom, $urandom}, 4'd7, 1'b0);
    send({$urandom, $urandom}, 4'd1, 1'b1);
    drain();

    // T4: 11-byte packet flushes as FF then 07, input blocked in between
    send({$urandom, $urandom}, 4'd6, 1'b0);
    send({$urandom, $urandom}, 4'd5, 1'b1);
    check("t4_ready_blocked", 64'(bus.s_ready), 64'd0);
    check("t4_first_keep", 64'(bus.m_keep), 64'hFF);
    check("t4_first_last", 64'(bus.m_last), 64'd0);
    step();
    check("t4_last_keep", 64'(bus.m_keep), 64'h07);
    check("t4_last_last", 64'(bus.m_last), 64'd1);
    check("t4_ready_after", 64'(bus.s_ready), 64'd1);
    drain();

    // T5: backpressure with three full words
    tb_ready = 1'b0;
    w0 = {$urandom, $urandom};
    send(w0, 4'd8, 1'b0);
    send({$urandom, $urandom}, 4'd8, 1'b0);
    send({$urandom, $urandom}, 4'd8, 1'b1);
    check("t5_ready_full", 64'(bus.s_ready), 64'd0);
    check("t5_m_valid", 64'(bus.m_valid), 64'd1);
    repeat (3) step();
    check("t5_data_stable", bus.m_data, w0);
    drain();

    // T6: zero-length last on an empty accumulator
    send({$urandom, $urandom}, 4'd0, 1'b1);
    drain();

    // Random packets, byte counts 0..10 (clamped), random backpressure
    rand_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      nw = $urandom_range(1, 5);
      for (int w = 0; w < nw; w++) begin
        send({$urandom, $urandom}, 4'($urandom_range(0, 10)), w == nw - 1);
        if ($urandom_range(0, 3) == 0) step();
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
